// File: rtl/mac_pkg.sv
// Shared types and the extended-operand multiply for the MAC array.
// Build option MAC_SAT_EN selects a saturating accumulator in mac_lane.
package mac_pkg;

    localparam int MAC_DW = 8;
    localparam int PW = 2 * MAC_DW + 2;

    typedef enum logic {
        IDLE,
        ACC
    } acc_state_e;

    // Each operand gains one bit so signed and unsigned share one signed multiplier.
    function automatic logic signed [PW-1:0] mul_ext(
        input logic [MAC_DW-1:0] a,
        input logic              a_sgn,
        input logic [MAC_DW-1:0] w,
        input logic              w_sgn
    );
        logic signed [MAC_DW:0] ax;
        logic signed [MAC_DW:0] wx;
        ax = $signed({a_sgn & a[MAC_DW-1], a});
        wx = $signed({w_sgn & w[MAC_DW-1], w});
        return ax * wx;
    endfunction

endpackage

// File: rtl/mac_acc_array_lane.sv
// One lane of the MAC array: product register, accumulator and result register.
// With MAC_SAT_EN the accumulator clamps and reports a sticky overflow.
module mac_lane
    import mac_pkg::*;
#(
    parameter int ACCW = 2 * MAC_DW + 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [MAC_DW-1:0] a,
    input  logic [MAC_DW-1:0] w,
    input  logic              a_sgn,
    input  logic              w_sgn,
    input  logic              beat,
    input  logic              start,
    input  logic              last,
    output logic [ACCW-1:0]   q,
    output logic              ovf
);

    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] pext;
    logic signed [ACCW-1:0] base;
    logic signed [ACCW-1:0] acc_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod <= '0;
        end else if (en) begin
            prod <= mul_ext(a, a_sgn, w, w_sgn);
        end
    end

    assign pext = ACCW'(prod);
    assign base = start ? '0 : acc;

`ifdef MAC_SAT_EN
    logic signed [ACCW:0] sum;
    logic                 clamp;
    logic                 ovf_acc;
    logic                 ovf_nx;

    assign sum   = {base[ACCW-1], base} + {pext[ACCW-1], pext};
    // Top two bits disagree only when the true sum left the ACCW range.
    assign clamp = sum[ACCW] != sum[ACCW-1];
    assign acc_nx = !clamp ? sum[ACCW-1:0]
                  : sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}}
                  : {1'b0, {(ACCW-1){1'b1}}};
    assign ovf_nx = (start ? 1'b0 : ovf_acc) | clamp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_acc <= 1'b0;
            ovf     <= 1'b0;
        end else if (en && beat) begin
            ovf_acc <= ovf_nx;
            if (last) begin
                ovf <= ovf_nx;
            end
        end
    end
`else
    assign acc_nx = base + pext;
    assign ovf    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            q   <= '0;
        end else if (en && beat) begin
            acc <= acc_nx;
            if (last) begin
                q <= acc_nx;
            end
        end
    end

endmodule

// File: rtl/mac_acc_array.sv
// Multi-lane pipelined MAC with burst accumulation and valid/ready on both sides.
// Define MAC_SAT_EN for saturating accumulation with per-lane ovf flags.
module mac_acc_array
    import mac_pkg::*;
#(
    parameter int DW    = MAC_DW,
    parameter int LANES = 4,
    parameter int ACCW  = 2 * DW + 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   A,
    input  logic [LANES*DW-1:0]   W,
    input  logic                  Asigned,
    input  logic                  Wsigned,
    input  logic                  acc_clr,
    input  logic                  acc_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*ACCW-1:0] Q,
    output logic [LANES-1:0]      ovf
);

    logic                en;
    logic                v1;
    logic                v2;
    logic                as1;
    logic                ws1;
    logic                clr1;
    logic                clr2;
    logic                last1;
    logic                last2;
    logic [LANES*DW-1:0] a1;
    logic [LANES*DW-1:0] w1;
    logic                start;
    acc_state_e          state;
    acc_state_e          state_nx;

    // A result parked at the output stalls the whole pipe.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            a1    <= '0;
            w1    <= '0;
            as1   <= 1'b0;
            ws1   <= 1'b0;
            clr1  <= 1'b0;
            last1 <= 1'b0;
            v2    <= 1'b0;
            clr2  <= 1'b0;
            last2 <= 1'b0;
        end else if (en) begin
            v1    <= in_valid;
            a1    <= A;
            w1    <= W;
            as1   <= Asigned;
            ws1   <= Wsigned;
            clr1  <= acc_clr;
            last1 <= acc_last;
            v2    <= v1;
            clr2  <= clr1;
            last2 <= last1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        start    = v2 && (clr2 || state == IDLE);
        if (en && v2) begin
            state_nx = last2 ? IDLE : ACC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (en) begin
            out_valid <= v2 && last2;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane #(
            .ACCW(ACCW)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en),
            .a    (a1[i*DW +: DW]),
            .w    (w1[i*DW +: DW]),
            .a_sgn(as1),
            .w_sgn(ws1),
            .beat (v2),
            .start(start),
            .last (last2),
            .q    (Q[i*ACCW +: ACCW]),
            .ovf  (ovf[i])
        );
    end

endmodule

// File: tb/tb_mac_acc_array.sv
// Self-checking bench for mac_acc_array: directed bursts plus random traffic
// scored against an arithmetic model of the accumulate rules.
module tb_mac_acc_array;

    localparam int DW    = 8;
    localparam int LANES = 2;
    localparam int ACCW  = 24;
    localparam int AW    = LANES * DW;
    localparam int QW    = LANES * ACCW;
    localparam longint MAXV = (longint'(1) << (ACCW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (ACCW - 1));
    localparam longint MODV = longint'(1) << ACCW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [AW-1:0]    A = '0;
    logic [AW-1:0]    W = '0;
    logic             Asigned = 1'b0;
    logic             Wsigned = 1'b0;
    logic             acc_clr = 1'b0;
    logic             acc_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [QW-1:0]    Q;
    logic [LANES-1:0] ovf;

    mac_acc_array #(
        .DW(DW),
        .LANES(LANES),
        .ACCW(ACCW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .W        (W),
        .Asigned  (Asigned),
        .Wsigned  (Wsigned),
        .acc_clr  (acc_clr),
        .acc_last (acc_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Q        (Q),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [QW-1:0]    q;
        logic [LANES-1:0] ovf;
    } res_t;

    res_t   expq[$];
    res_t   mon_r;
    longint msum[LANES];
    logic   movf[LANES];
    bit     in_burst = 1'b0;
    bit     mon_en = 1'b0;
    bit     stalled = 1'b0;
    logic [QW-1:0]    held_q;
    logic [LANES-1:0] held_ovf;
    int     vectors = 0;
    int     miscompares = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint ext(logic [DW-1:0] v, logic s);
        return s ? longint'($signed(v)) : longint'(v);
    endfunction

    // Reference: sum of products per lane, restarted on clr or outside a burst.
    task automatic model_beat(logic [AW-1:0] a, logic [AW-1:0] w,
                              logic as, logic ws, logic clr, logic last);
        res_t r;
        for (int i = 0; i < LANES; i++) begin
            if (clr || !in_burst) begin
                msum[i] = 0;
                movf[i] = 1'b0;
            end
            msum[i] += ext(a[i*DW +: DW], as) * ext(w[i*DW +: DW], ws);
`ifdef MAC_SAT_EN
            if (msum[i] > MAXV) begin
                msum[i] = MAXV;
                movf[i] = 1'b1;
            end else if (msum[i] < MINV) begin
                msum[i] = MINV;
                movf[i] = 1'b1;
            end
`else
            msum[i] = msum[i] & (MODV - 1);
            if (msum[i] > MAXV) msum[i] -= MODV;
`endif
            r.q[i*ACCW +: ACCW] = msum[i][ACCW-1:0];
            r.ovf[i] = movf[i];
        end
        in_burst = !last;
        if (last) expq.push_back(r);
    endtask

    task automatic send(logic [AW-1:0] a, logic [AW-1:0] w, logic as, logic ws,
                        logic clr, logic last, bit rnd_ready);
        int n = 0;
        bit ok = 1'b1;
        @(negedge clk);
        A = a;
        W = w;
        Asigned = as;
        Wsigned = ws;
        acc_clr = clr;
        acc_last = last;
        in_valid = 1'b1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        while (!in_ready) begin
            n++;
            if (n > 60) begin
                vectors++;
                miscompares++;
                $error("FAIL in_ready_timeout observed=0 expected=1");
                ok = 1'b0;
                break;
            end
            @(negedge clk);
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            #1;
        end
        if (ok) model_beat(a, w, as, ws, clr, last);
    endtask

    task automatic idle(int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #2;
            if (expq.size() == 0 && !out_valid) break;
        end
        chk("drain_left", 64'(expq.size()), 64'(0));
    endtask

    task automatic wait_result(string tag, logic [ACCW-1:0] e0, logic [ACCW-1:0] e1);
        int n;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(3));
        chk({tag, "_q0"}, 64'(Q[0 +: ACCW]), 64'(e0));
        chk({tag, "_q1"}, 64'(Q[ACCW +: ACCW]), 64'(e1));
    endtask

    always @(negedge clk) begin
        #1;
        if (mon_en && rst_n) begin
            if (stalled) begin
                chk("hold_q", 64'(Q), 64'(held_q));
                chk("hold_ovf", 64'(ovf), 64'(held_ovf));
                chk("hold_valid", 64'(out_valid), 64'(1));
            end
            chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL spurious_result observed=%0h expected=none", Q);
                end else begin
                    mon_r = expq.pop_front();
                    chk("q", 64'(Q), 64'(mon_r.q));
                    chk("ovf", 64'(ovf), 64'(mon_r.ovf));
                end
            end
            stalled  = out_valid && !out_ready;
            held_q   = Q;
            held_ovf = ovf;
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_q", 64'(Q), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        out_ready = 1'b1;

        // Unsigned burst of four 255*255 beats
        for (int k = 0; k < 4; k++)
            send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, k == 0, k == 3, 1'b0);
        wait_result("unsigned", ACCW'(260100), ACCW'(260100));

        // Signed and mixed single-beat results
        send(16'h8080, 16'h8080, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_result("ss", ACCW'(16384), ACCW'(16384));
        send(16'h8080, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_result("su", ACCW'(-32640), ACCW'(-32640));
        send(16'hFFFF, 16'h8080, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_result("us", ACCW'(-32640), ACCW'(-32640));

        // Backpressure: result parked, next beat must wait
        drain();
        out_ready = 1'b0;
        send(16'h0A0A, 16'h0A0A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send(16'h0A0A, 16'h0A0A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_result("bp", ACCW'(200), ACCW'(200));
        A = 16'h0706;
        W = 16'h0607;
        Asigned = 1'b0;
        Wsigned = 1'b0;
        acc_clr = 1'b1;
        acc_last = 1'b1;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #2;
            chk("bp_in_ready", 64'(in_ready), 64'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_accept", 64'(in_ready), 64'(1));
        model_beat(16'h0706, 16'h0607, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_result("bp_next", ACCW'(42), ACCW'(42));

        // Mid-burst clr discards the partial sum
        send(16'h0303, 16'h0303, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send(16'h0303, 16'h0303, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(16'h0101, 16'h0101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_result("midclr", ACCW'(1), ACCW'(1));

        // Accumulator range limit: 520 beats of (-128)*(-128)
        for (int k = 0; k < 520; k++)
            send(16'h8080, 16'h8080, 1'b1, 1'b1, k == 0, k == 519, 1'b0);
`ifdef MAC_SAT_EN
        wait_result("range", ACCW'(8388607), ACCW'(8388607));
        chk("range_ovf", 64'(ovf), 64'(2'b11));
`else
        wait_result("range", ACCW'(-8257536), ACCW'(-8257536));
        chk("range_ovf", 64'(ovf), 64'(2'b00));
`endif
        // Back-to-back burst after the range test resets ovf
        send(16'h0102, 16'h0304, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_result("after_range", ACCW'(8), ACCW'(3));
        chk("after_range_ovf", 64'(ovf), 64'(0));

        // Random traffic with random backpressure
        for (int b = 0; b < 40; b++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++)
                send(AW'($urandom), AW'($urandom), 1'($urandom), 1'($urandom),
                     (k == 0) ? 1'($urandom) : ($urandom_range(0, 7) == 0),
                     k == len - 1, 1'b1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        drain();

        // Reset mid-accumulation loses the partial sum
        send(16'h0909, 16'h0909, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send(16'h0909, 16'h0909, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        rst_n = 1'b0;
        in_burst = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #2;
            chk("post_rst_valid", 64'(out_valid), 64'(0));
        end
        send(16'h0505, 16'h0505, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_result("post_rst", ACCW'(25), ACCW'(25));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
